// File: rtl/native_port_buffer_if.sv
// Native-port and controller user-port signal bundle for native_port_buffer.
// slave is the buffer's view; master is the surrounding environment's view.
interface native_port_buffer_if #(
    parameter int ADDR_WIDTH  = 25,
    parameter int DATA_WIDTH  = 256,
    parameter int RDATA_DEPTH = 8
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int CW       = $clog2(RDATA_DEPTH + 1);

    logic                  native_cmd_valid;
    logic                  native_cmd_ready;
    logic                  native_cmd_payload_we;
    logic [ADDR_WIDTH-1:0] native_cmd_payload_addr;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] wdata_payload_data;
    logic [BE_WIDTH-1:0]   wdata_payload_we;
    logic                  rdata_valid;
    logic                  rdata_ready;
    logic                  rdata_first;
    logic                  rdata_last;
    logic [DATA_WIDTH-1:0] rdata_payload_data;
    logic                  ctrl_cmd_valid;
    logic                  ctrl_cmd_ready;
    logic                  ctrl_cmd_we;
    logic [ADDR_WIDTH-1:0] ctrl_cmd_addr;
    logic                  ctrl_wdata_valid;
    logic                  ctrl_wdata_ready;
    logic [DATA_WIDTH-1:0] ctrl_wdata_data;
    logic [BE_WIDTH-1:0]   ctrl_wdata_we;
    logic                  ctrl_rdata_valid;
    logic [DATA_WIDTH-1:0] ctrl_rdata_data;
    logic [CW-1:0]         rd_credits;
    logic                  rdata_overflow;

    modport slave (
        input  native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
        output native_cmd_ready,
        input  wdata_valid, wdata_payload_data, wdata_payload_we,
        output wdata_ready,
        output rdata_valid, rdata_first, rdata_last, rdata_payload_data,
        input  rdata_ready,
        output ctrl_cmd_valid, ctrl_cmd_we, ctrl_cmd_addr,
        input  ctrl_cmd_ready,
        output ctrl_wdata_valid, ctrl_wdata_data, ctrl_wdata_we,
        input  ctrl_wdata_ready,
        input  ctrl_rdata_valid, ctrl_rdata_data,
        output rd_credits, rdata_overflow
    );

    modport master (
        output native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
        input  native_cmd_ready,
        output wdata_valid, wdata_payload_data, wdata_payload_we,
        input  wdata_ready,
        input  rdata_valid, rdata_first, rdata_last, rdata_payload_data,
        output rdata_ready,
        input  ctrl_cmd_valid, ctrl_cmd_we, ctrl_cmd_addr,
        output ctrl_cmd_ready,
        input  ctrl_wdata_valid, ctrl_wdata_data, ctrl_wdata_we,
        output ctrl_wdata_ready,
        output ctrl_rdata_valid, ctrl_rdata_data,
        input  rd_credits, rdata_overflow
    );
endinterface

// File: rtl/native_port_buffer.sv
// Command/write/read FIFO decoupling between the native port and the
// LPDDR4 controller, with read-credit gating so read data is never lost.
module npb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = (wp == rp);
    // Head is forced to zero when empty so idle payloads read as 0
    assign dout  = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + 1'b1;
            if (pop && !empty)
                rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wp[AW-1:0]] <= din;
    end
endmodule

module native_port_buffer #(
    parameter int ADDR_WIDTH  = 25,
    parameter int DATA_WIDTH  = 256,
    parameter int CMD_DEPTH   = 4,
    parameter int WDATA_DEPTH = 8,
    parameter int RDATA_DEPTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    native_port_buffer_if.slave bus
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(RDATA_DEPTH + 1);

    logic                  up;
    logic                  cmd_full, cmd_empty;
    logic [ADDR_WIDTH:0]   cmd_head;
    logic                  wd_full, wd_empty;
    logic [BW+DATA_WIDTH-1:0] wd_head;
    logic                  rd_full, rd_empty;
    logic [CW-1:0]         credits;
    logic                  ovf;
    logic                  rd_issue, rd_pop;

    // Readies stay low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            up <= 1'b0;
        else
            up <= 1'b1;
    end

    assign bus.native_cmd_ready = up && !cmd_full;
    assign bus.wdata_ready      = up && !wd_full;

    npb_fifo #(.W(ADDR_WIDTH + 1), .DEPTH(CMD_DEPTH)) u_cmd (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.native_cmd_valid && bus.native_cmd_ready),
        .pop   (bus.ctrl_cmd_valid && bus.ctrl_cmd_ready),
        .din   ({bus.native_cmd_payload_we, bus.native_cmd_payload_addr}),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    // A read at the head waits for a credit and blocks everything behind it
    assign bus.ctrl_cmd_valid = !cmd_empty && (cmd_head[ADDR_WIDTH] || credits != '0);
    assign bus.ctrl_cmd_we    = cmd_head[ADDR_WIDTH];
    assign bus.ctrl_cmd_addr  = cmd_head[ADDR_WIDTH-1:0];

    npb_fifo #(.W(BW + DATA_WIDTH), .DEPTH(WDATA_DEPTH)) u_wd (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wdata_valid && bus.wdata_ready),
        .pop   (bus.ctrl_wdata_valid && bus.ctrl_wdata_ready),
        .din   ({bus.wdata_payload_we, bus.wdata_payload_data}),
        .dout  (wd_head),
        .full  (wd_full),
        .empty (wd_empty)
    );

    assign bus.ctrl_wdata_valid = !wd_empty;
    assign bus.ctrl_wdata_we    = wd_head[BW+DATA_WIDTH-1:DATA_WIDTH];
    assign bus.ctrl_wdata_data  = wd_head[DATA_WIDTH-1:0];

    npb_fifo #(.W(DATA_WIDTH), .DEPTH(RDATA_DEPTH)) u_rd (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ctrl_rdata_valid),
        .pop   (rd_pop),
        .din   (bus.ctrl_rdata_data),
        .dout  (bus.rdata_payload_data),
        .full  (rd_full),
        .empty (rd_empty)
    );

    assign bus.rdata_valid = !rd_empty;
    assign bus.rdata_first = 1'b1;
    assign bus.rdata_last  = 1'b1;

    assign rd_issue = bus.ctrl_cmd_valid && bus.ctrl_cmd_ready && !bus.ctrl_cmd_we;
    assign rd_pop   = bus.rdata_valid && bus.rdata_ready;

    // Saturate at the top so unsolicited beats cannot inflate the credits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CW'(RDATA_DEPTH);
        end else if (rd_issue && !rd_pop) begin
            credits <= credits - 1'b1;
        end else if (rd_pop && !rd_issue && credits < CW'(RDATA_DEPTH)) begin
            credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (bus.ctrl_rdata_valid && rd_full)
            ovf <= 1'b1;
    end

    assign bus.rd_credits     = credits;
    assign bus.rdata_overflow = ovf;
endmodule

// File: doc/native_port_buffer.md
Name: native_port_buffer

Overview:
Decoupling stage directly downstream of the AXI-to-native converter, between the native port and the LPDDR4 controller's user port. It buffers native commands and write data in FIFOs and holds returning read data in a FIFO. The controller's read-data path has no backpressure, so the block admits read commands only while read-data credits remain, which guarantees that read data is never dropped.

Parameters:
ADDR_WIDTH, 25, native command address width (word address)
DATA_WIDTH, 256, native data width; byte-enable width is DATA_WIDTH/8
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
WDATA_DEPTH, 8, write-data FIFO entries (power of two, >=2)
RDATA_DEPTH, 8, read-data FIFO entries and read credit count (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
native_cmd_valid  in  1  upstream command valid
native_cmd_ready  out  1  command FIFO not full
native_cmd_payload_we  in  1  1=write, 0=read
native_cmd_payload_addr  in  ADDR_WIDTH  command address
wdata_valid  in  1  upstream write-data valid
wdata_ready  out  1  write-data FIFO not full
wdata_payload_data  in  DATA_WIDTH  write data
wdata_payload_we  in  DATA_WIDTH/8  byte enables
rdata_valid  out  1  read-data FIFO not empty
rdata_ready  in  1  upstream accepts read data
rdata_first  out  1  constant 1 (single-beat transfer)
rdata_last  out  1  constant 1 (single-beat transfer)
rdata_payload_data  out  DATA_WIDTH  read data
ctrl_cmd_valid  out  1  command to controller
ctrl_cmd_ready  in  1  controller accepts command
ctrl_cmd_we  out  1  write flag
ctrl_cmd_addr  out  ADDR_WIDTH  address
ctrl_wdata_valid  out  1  write data to controller
ctrl_wdata_ready  in  1  controller accepts write data
ctrl_wdata_data  out  DATA_WIDTH  write data
ctrl_wdata_we  out  DATA_WIDTH/8  byte enables
ctrl_rdata_valid  in  1  read data from controller (no ready)
ctrl_rdata_data  in  DATA_WIDTH  read data
rd_credits  out  $clog2(RDATA_DEPTH+1)  available read credits
rdata_overflow  out  1  sticky error flag

Behaviour:
- Reset: all FIFOs are empty. All valids and native_cmd_ready/wdata_ready are 0 while rst is asserted and go to 1 on the first cycle after it is released. rd_credits = RDATA_DEPTH. rdata_overflow = 0. Data outputs are 0. rdata_first and rdata_last are always 1.
- Handshakes: a transfer occurs when valid && ready are both 1 on a clk edge. Once asserted, valid and payload must stay stable until the transfer occurs; this applies to both sides.
- Ready signals are driven only from FIFO occupancy: ready = count < DEPTH. There is no combinational path from downstream ready to upstream ready, so a full FIFO with a simultaneous pop still deasserts ready for that cycle.
- Latency:
  - A command pushed at edge N is visible on ctrl_cmd_* after edge N, i.e. in cycle N+1. Same for write data.
  - ctrl_rdata_valid sampled at edge N produces rdata_valid in cycle N+1.
  - Empty-FIFO bypass is not allowed.
- Command order is preserved. Write data is forwarded independently of write commands. The downstream controller pairs them in order; the block does not check counts.
- Read gating: the head command is presented on ctrl_cmd_valid only if it is a write or rd_credits > 0. A read at the head with rd_credits == 0 holds ctrl_cmd_valid = 0 and blocks all later commands (in-order).
- Credits:
  - Decrement by 1 on a read command transfer (ctrl_cmd_valid && ctrl_cmd_ready && !ctrl_cmd_we).
  - Increment by 1 on an upstream rdata pop (rdata_valid && rdata_ready).
  - Both in the same cycle: no change.
  - Never below 0 or above RDATA_DEPTH. The invariant is: credits + reads in flight + rdata FIFO occupancy = RDATA_DEPTH.
- Read-data FIFO: every ctrl_rdata_valid beat is pushed. If it arrives while the FIFO is full (controller protocol violation), the beat is discarded and rdata_overflow is set. The flag stays set until reset.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full means the MSBs differ and the rest of the pointers are equal. Simultaneous push and pop at any occupancy leaves the count unchanged.
- Reset mid-operation clears everything asynchronously. Reads in flight are forgotten and credits return to RDATA_DEPTH. The controller must be reset together with this block.

Test Plan:
- Single write: one native cmd (we=1, addr=0x10) plus one wdata beat (data=0xA5.., be=all 1) -> ctrl_cmd_* and ctrl_wdata_* appear 1 cycle later with identical values; ctrl ready=1 drains them in 1 cycle.
- Credit exhaustion: issue 10 reads (addr 0..9) with rdata_ready=0 and the controller returning data 3 cycles after each cmd -> exactly 8 ctrl reads issued, rd_credits=0, ctrl_cmd_valid=0; asserting rdata_ready releases reads 8 and 9 one per popped beat; all 10 beats return in order; rdata_overflow stays 0.
- Backpressure: ctrl_cmd_ready=0 with 5 commands offered -> native_cmd_ready falls after 4 accepted; one ctrl accept -> ready rises the next cycle; order preserved.
- Simultaneous credit events: read cmd accepted in the same cycle as an rdata pop with rd_credits=3 -> rd_credits remains 3.
- Overflow detection: force 9 ctrl_rdata_valid beats with no reads issued and rdata_ready=0 -> 8 stored, 9th discarded, rdata_overflow=1 and sticky.
- Async reset with 4 reads in flight and 2 rdata buffered -> all valids are 0 during rst; after release rd_credits=8, FIFOs empty, rdata_overflow=0.
